// File: rtl/adaptive_traffic_ctrl_n.sv
// N-way adaptive traffic-light controller: densest approach wins, round-robin on ties,
// density-scaled green, yellow and all-red clearance. Optional ATC_EMERGENCY_EN adds emg_req.
module adaptive_traffic_ctrl_n #(
   parameter int N_WAY      = 4,
   parameter int SENS_W     = 2,
   parameter int GREEN_BASE = 8,
   parameter int GREEN_STEP = 4,
   parameter int YELLOW_T   = 3,
   parameter int ALLRED_T   = 1,
   parameter int TIMER_W    = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_WAY*SENS_W-1:0]     sens,
`ifdef ATC_EMERGENCY_EN
   input  logic [N_WAY-1:0]            emg_req,
`endif
   output logic [N_WAY*3-1:0]          light,
   output logic [$clog2(N_WAY)-1:0]    cur_way,
   output logic                        phase_start
);

   localparam int WAY_W = $clog2(N_WAY);

   localparam logic [1:0] S_ALLRED = 2'd0;
   localparam logic [1:0] S_GREEN  = 2'd1;
   localparam logic [1:0] S_YELLOW = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [WAY_W-1:0]     cur_q, cur_d;
   logic [WAY_W-1:0]     tgt_q, tgt_d;
   logic                 boot_q, boot_d;
   logic                 ps_q, ps_d;
   logic [N_WAY*3-1:0]   light_q, light_d;

   logic [SENS_W-1:0]    maxd;
   logic [SENS_W-1:0]    cur_dens;
   logic [WAY_W-1:0]     next_way, init_way;
   logic [TIMER_W-1:0]   g_m1, t_now;
   logic                 emg_v;
   logic [WAY_W-1:0]     emg_way;

   // First approach at density m, scanning start, start+1, ... with wrap.
   function automatic logic [WAY_W-1:0] scan_from(input int start,
                                                  input logic [SENS_W-1:0] m,
                                                  input logic [N_WAY*SENS_W-1:0] s);
      logic [WAY_W-1:0] r;
      logic             hit;
      int               idx;
      r   = '0;
      hit = 1'b0;
      for (int k = 0; k < N_WAY; k++) begin
         idx = (start + k) % N_WAY;
         if (!hit && s[idx*SENS_W +: SENS_W] == m) begin
            r   = idx[WAY_W-1:0];
            hit = 1'b1;
         end
      end
      return r;
   endfunction

   always_comb begin
      maxd = '0;
      for (int i = 0; i < N_WAY; i++) begin
         if (sens[i*SENS_W +: SENS_W] > maxd) maxd = sens[i*SENS_W +: SENS_W];
      end
   end

   assign next_way = scan_from(int'(cur_q) + 1, maxd, sens);
   assign init_way = scan_from(0, maxd, sens);
   assign cur_dens = sens[cur_q*SENS_W +: SENS_W];
   assign g_m1     = TIMER_W'(GREEN_BASE - 1) + TIMER_W'(GREEN_STEP) * TIMER_W'(cur_dens);
   // Green length is only known on its first cycle, so the timer is loaded from there.
   assign t_now    = ps_q ? g_m1 : timer_q;

`ifdef ATC_EMERGENCY_EN
   always_comb begin
      emg_v   = 1'b0;
      emg_way = '0;
      for (int i = N_WAY - 1; i >= 0; i--) begin
         if (emg_req[i]) begin
            emg_v   = 1'b1;
            emg_way = i[WAY_W-1:0];
         end
      end
   end
`else
   assign emg_v   = 1'b0;
   assign emg_way = '0;
`endif

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      cur_d   = cur_q;
      tgt_d   = tgt_q;
      boot_d  = boot_q;
      ps_d    = 1'b0;
      case (state_q)
         S_GREEN: begin
            if (emg_v && emg_way == cur_q) begin
               timer_d = t_now;
            end else if (emg_v) begin
               state_d = S_YELLOW;
               timer_d = TIMER_W'(YELLOW_T - 1);
               tgt_d   = emg_way;
            end else if (t_now != '0) begin
               timer_d = t_now - 1'b1;
            end else if (maxd == '0 || next_way == cur_q) begin
               ps_d    = 1'b1;
               timer_d = '0;
            end else begin
               state_d = S_YELLOW;
               timer_d = TIMER_W'(YELLOW_T - 1);
               tgt_d   = next_way;
            end
         end
         S_YELLOW: begin
            if (emg_v) tgt_d = emg_way;
            if (timer_q == '0) begin
               state_d = S_ALLRED;
               timer_d = TIMER_W'(ALLRED_T - 1);
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: begin
            if (emg_v) begin
               tgt_d  = emg_way;
               boot_d = 1'b0;
            end
            if (timer_q == '0) begin
               state_d = S_GREEN;
               ps_d    = 1'b1;
               boot_d  = 1'b0;
               cur_d   = emg_v ? emg_way : (boot_q ? init_way : tgt_q);
               timer_d = '0;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      light_d = '0;
      for (int i = 0; i < N_WAY; i++) begin
         if (state_d == S_GREEN && cur_d == i[WAY_W-1:0])       light_d[i*3 +: 3] = 3'b001;
         else if (state_d == S_YELLOW && cur_d == i[WAY_W-1:0]) light_d[i*3 +: 3] = 3'b010;
         else                                                   light_d[i*3 +: 3] = 3'b100;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_ALLRED;
         timer_q <= TIMER_W'(ALLRED_T - 1);
         cur_q   <= '0;
         tgt_q   <= '0;
         boot_q  <= 1'b1;
         ps_q    <= 1'b0;
         light_q <= {N_WAY{3'b100}};
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         boot_q  <= boot_d;
         ps_q    <= ps_d;
         light_q <= light_d;
      end
   end

   assign light       = light_q;
   assign cur_way     = cur_q;
   assign phase_start = ps_q;

endmodule
